sum_xor_decoder: RTL and testbench
==================================

// Module: sum_xor_decoder
//
// PURPOSE
//  Receive-side inverse of the (A+B)^C encoder path: recovers A = (Q ^ C) - B mod 2^WIDTH.
//  Operands and codeword arrive together on a valid/ready stream.
//  Three-stage pipeline with full backpressure; counts delivered words.
//  Sits after the encoder/pipelined-encoder stage so the pair can be checked end to end.
//
// PARAMETERS
//  WIDTH      4  data width of Q, B, C and recovered A
//  CNT_WIDTH  8  width of delivered-word counter
//
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          Q/B/C valid this cycle
//  in_ready   out  1          block can accept; transfer when in_valid && in_ready
//  in_q       in   WIDTH      encoded word (A+B)^C
//  in_b       in   WIDTH      operand B used by the encoder
//  in_c       in   WIDTH      operand C used by the encoder
//  out_valid  out  1          out_a valid
//  out_ready  in   1          downstream accepts; transfer when out_valid && out_ready
//  out_a      out  WIDTH      recovered A
//  word_cnt   out  CNT_WIDTH  number of output transfers since reset
//
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all stage valids=0, out_valid=0, out_a=0, word_cnt=0, data regs=0.
//    Reset mid-stream discards all in-flight words; no output transfer occurs on the reset edge.
//  - Stage S0: registers in_q, in_b, in_c, s0_v on input transfer.
//  - Stage S1: x = s0_q ^ s0_c; registers x, s0_b, s1_v.
//  - Stage S2 (output regs): out_a <= s1_x - s1_b, truncated to WIDTH (mod 2^WIDTH, borrow dropped).
//  - Latency: word transferred in cycle n, with no stall, has out_valid=1 in cycle n+3.
//  - Throughput: one word/cycle when out_ready held high.
//  - Ready chain (combinational, upstream of each register):
//      r2 = !out_valid || out_ready;  r1 = !s1_v || r2;  in_ready = !s0_v || r1.
//    A stage loads only when its ready is 1; otherwise holds data and valid.
//  - Valid bubbles: a stage whose upstream is empty while it advances clears its valid.
//  - out_a and out_valid remain stable while out_valid && !out_ready (no drop, no duplicate).
//  - Simultaneous output transfer and new input when full: both occur; pipeline shifts by one.
//  - word_cnt increments on every out_valid && out_ready; wraps 2^CNT_WIDTH-1 -> 0.
//  - in_ready does not depend on in_valid. No combinational in->out data path.
//  - Data from a non-transfer input cycle (in_valid=0 or in_ready=0) is never loaded.
//
// STRUCTURE
//  - Package sum_xor_pkg: WIDTH default, encode function (a+b)^c and decode function (q^c)-b,
//    shared with the encoder bench for golden models.
//  - One sub-module, pipe_stage: generic valid/ready register slice (data width param);
//    instantiated three times, combinational XOR/subtract placed between slices.
//
// TESTING
//  1 Reset: rst=1 for 2 cycles -> out_valid=0, out_a=0, word_cnt=0, in_ready=1.
//  2 Basic: q=15,b=7,c=3 in cycle n, out_ready=1 -> out_a=5, out_valid in cycle n+3, word_cnt=1.
//  3 Wrap: q=2,b=9,c=0 -> out_a=9 (2-9 mod 16); q=0,b=0,c=0 -> out_a=0.
//  4 Backpressure: stream 5 words, out_ready=0 from cycle 2 -> in_ready drops after 3 words
//    held; release -> all 5 out in order, no loss/duplicate, word_cnt=5.
//  5 Random round-trip: 1000 random A,B,C encoded via package fn, random in_valid/out_ready
//    -> every out_a equals its A in order; word_cnt=1000 mod 256=232.
//  6 Reset mid-operation: 3 words in flight, rst=1 one cycle -> out_valid=0 next cycle,
//    word_cnt=0, next input decodes correctly with latency 3.

Source files
------------

// File: rtl/sum_xor_pkg.sv
// Shared definitions for the (A+B)^C encoder / decoder pair.
// The encode/decode functions serve as golden models for both benches.
package sum_xor_pkg;

    localparam int SXD_WIDTH     = 4;
    localparam int SXD_CNT_WIDTH = 8;

    typedef logic [SXD_WIDTH-1:0] word_t;

    function automatic word_t sxd_encode(input word_t a, input word_t b, input word_t c);
        word_t sum;
        sum = a + b;
        return sum ^ c;
    endfunction

    // Borrow out of the subtraction is dropped, so this exactly undoes the carry-dropping add.
    function automatic word_t sxd_decode(input word_t q, input word_t b, input word_t c);
        word_t x;
        x = q ^ c;
        return x - b;
    endfunction

endpackage

// File: rtl/sum_xor_decoder_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when downstream accepts,
// otherwise holds both data and valid.
module pipe_stage #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            // An empty upstream while advancing inserts a bubble; data only moves on a real transfer.
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/sum_xor_decoder.sv
// Three-stage backpressured decoder recovering A = (Q ^ C) - B mod 2^WIDTH,
// with a wrapping count of delivered words.
module sum_xor_decoder
    import sum_xor_pkg::*;
#(
    parameter int WIDTH     = SXD_WIDTH,
    parameter int CNT_WIDTH = SXD_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_q,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_a,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    logic                 w_s0_valid;
    logic                 w_s1_valid;
    logic                 w_r1;
    logic                 w_r2;
    logic [3*WIDTH-1:0]   w_s0_data;
    logic [2*WIDTH-1:0]   w_s1_in;
    logic [2*WIDTH-1:0]   w_s1_data;
    logic [WIDTH-1:0]     w_s0_q;
    logic [WIDTH-1:0]     w_s0_b;
    logic [WIDTH-1:0]     w_s0_c;
    logic [WIDTH-1:0]     w_s1_x;
    logic [WIDTH-1:0]     w_s1_b;
    logic [WIDTH-1:0]     w_diff;
    logic [CNT_WIDTH-1:0] r_word_cnt;

    pipe_stage #(.DW(3*WIDTH)) u_s0 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .i_data  ({in_q, in_b, in_c}),
        .i_ready (w_r1),
        .o_ready (in_ready),
        .o_valid (w_s0_valid),
        .o_data  (w_s0_data)
    );

    assign w_s0_q  = w_s0_data[3*WIDTH-1:2*WIDTH];
    assign w_s0_b  = w_s0_data[2*WIDTH-1:WIDTH];
    assign w_s0_c  = w_s0_data[WIDTH-1:0];
    assign w_s1_in = {w_s0_q ^ w_s0_c, w_s0_b};

    pipe_stage #(.DW(2*WIDTH)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_s0_valid),
        .i_data  (w_s1_in),
        .i_ready (w_r2),
        .o_ready (w_r1),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_data)
    );

    assign w_s1_x = w_s1_data[2*WIDTH-1:WIDTH];
    assign w_s1_b = w_s1_data[WIDTH-1:0];
    assign w_diff = w_s1_x - w_s1_b;

    pipe_stage #(.DW(WIDTH)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_s1_valid),
        .i_data  (w_diff),
        .i_ready (out_ready),
        .o_ready (w_r2),
        .o_valid (out_valid),
        .o_data  (out_a)
    );

    // Reset takes priority, so a transfer coinciding with the reset edge is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_sum_xor_decoder.sv
// Self-checking bench for sum_xor_decoder: directed cases plus a randomized
// round-trip through the package encoder against an ordered scoreboard of A values.
module tb_sum_xor_decoder;
    import sum_xor_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_q = '0;
    logic [3:0] in_b = '0;
    logic [3:0] in_c = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_a;
    logic [7:0] word_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Values sampled on the falling edge of the most recent cycle.
    logic       s_in_ready, s_out_valid, s_in_fire, s_out_fire;
    logic [3:0] s_out_a;

    sum_xor_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive, sample mid-cycle, advance to just after the next rising edge.
    task automatic do_cycle(input logic r, input logic v, input logic [3:0] q,
                            input logic [3:0] b, input logic [3:0] c, input logic ordy);
        rst = r; in_valid = v; in_q = q; in_b = b; in_c = c; out_ready = ordy;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_a     = out_a;
        s_in_fire   = in_valid && in_ready && !rst;
        s_out_fire  = out_valid && out_ready && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        do_cycle(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1);
        do_cycle(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++;
        if (out_a !== 4'd0) begin n_fail++; $display("FAIL reset_out_a got=%0d exp=0", out_a); end
        n_tests++;
        if (word_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        $display("[TB] reset: out_valid=%b out_a=%0d word_cnt=%0d in_ready=%b", out_valid, out_a, word_cnt, in_ready);
    endtask

    task automatic test_basic;
        int k;
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        do_cycle(1'b0, 1'b1, 4'd15, 4'd7, 4'd3, 1'b1);
        n_tests++;
        if (s_in_fire !== 1'b1) begin n_fail++; $display("FAIL basic_accept got=%b exp=1", s_in_fire); end
        k = 0;
        do begin
            do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            k++;
        end while (!s_out_valid && k < 10);
        n_tests++;
        if (k !== 3) begin n_fail++; $display("FAIL basic_latency got=%0d exp=3", k); end
        n_tests++;
        if (s_out_a !== 4'd5) begin n_fail++; $display("FAIL basic_out_a got=%0d exp=5", s_out_a); end
        n_tests++;
        if (word_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_word_cnt got=%0d exp=1", word_cnt); end
        $display("[TB] basic: q=15 b=7 c=3 -> out_a=%0d latency=%0d word_cnt=%0d", s_out_a, k, word_cnt);
    endtask

    task automatic test_wrap;
        logic [3:0] exp_a [2];
        int got;
        int cyc;
        exp_a[0] = 4'd9;
        exp_a[1] = 4'd0;
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        do_cycle(1'b0, 1'b1, 4'd2, 4'd9, 4'd0, 1'b1);
        do_cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
        got = 0;
        cyc = 0;
        while (got < 2 && cyc < 12) begin
            do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            cyc++;
            if (s_out_fire) begin
                n_tests++;
                if (s_out_a !== exp_a[got]) begin
                    n_fail++; $display("FAIL wrap_out_a[%0d] got=%0d exp=%0d", got, s_out_a, exp_a[got]);
                end
                $display("[TB] wrap: word %0d out_a=%0d", got, s_out_a);
                got++;
            end
        end
        n_tests++;
        if (got !== 2) begin n_fail++; $display("FAIL wrap_count got=%0d exp=2", got); end
    endtask

    task automatic test_backpressure;
        logic [3:0] a [5];
        logic [3:0] b [5];
        logic [3:0] c [5];
        int sent, got, cyc;
        for (int i = 0; i < 5; i++) begin
            a[i] = 4'($urandom); b[i] = 4'($urandom); c[i] = 4'($urandom);
        end
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        sent = 0; got = 0;
        for (cyc = 0; cyc < 10; cyc++) begin
            if (sent < 5) do_cycle(1'b0, 1'b1, sxd_encode(a[sent], b[sent], c[sent]), b[sent], c[sent], cyc < 2);
            else          do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, cyc < 2);
            if (s_in_fire) sent++;
            if (s_out_fire) got++;
        end
        n_tests++;
        if (sent !== 3) begin n_fail++; $display("FAIL bp_held_words got=%0d exp=3", sent); end
        n_tests++;
        if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", s_in_ready); end
        n_tests++;
        if (got !== 0) begin n_fail++; $display("FAIL bp_early_out got=%0d exp=0", got); end
        $display("[TB] backpressure: held=%0d in_ready=%b", sent, s_in_ready);
        cyc = 0;
        while (got < 5 && cyc < 30) begin
            if (sent < 5) do_cycle(1'b0, 1'b1, sxd_encode(a[sent], b[sent], c[sent]), b[sent], c[sent], 1'b1);
            else          do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            cyc++;
            if (s_in_fire) sent++;
            if (s_out_fire) begin
                n_tests++;
                if (got >= 5 || s_out_a !== a[got]) begin
                    n_fail++; $display("FAIL bp_out_a[%0d] got=%0d exp=%0d", got, s_out_a, a[got]);
                end
                $display("[TB] backpressure: word %0d out_a=%0d", got, s_out_a);
                got++;
            end
        end
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        n_tests++;
        if (got !== 5 || s_out_fire) begin n_fail++; $display("FAIL bp_out_count got=%0d extra=%b exp=5", got, s_out_fire); end
        n_tests++;
        if (word_cnt !== 8'd5) begin n_fail++; $display("FAIL bp_word_cnt got=%0d exp=5", word_cnt); end
    endtask

    task automatic test_random;
        logic [3:0] exp_q [$];
        logic [3:0] a, b, c;
        logic       have, vld, ordy, prev_hold;
        logic [3:0] prev_a;
        int sent, got, cyc, bad;
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        sent = 0; got = 0; cyc = 0; bad = 0;
        have = 1'b0; prev_hold = 1'b0; prev_a = '0;
        a = '0; b = '0; c = '0;
        while (got < 1000 && cyc < 20000) begin
            if (!have && sent < 1000) begin
                a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); have = 1'b1;
            end
            vld  = have && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            do_cycle(1'b0, vld, sxd_encode(a, b, c), b, c, ordy);
            cyc++;
            if (prev_hold && (s_out_valid !== 1'b1 || s_out_a !== prev_a)) begin
                bad++;
                if (bad < 5) $display("FAIL rand_stall_hold valid=%b out_a=%0d exp=%0d", s_out_valid, s_out_a, prev_a);
            end
            prev_hold = s_out_valid && !ordy;
            prev_a    = s_out_a;
            if (s_in_fire) begin
                exp_q.push_back(a); sent++; have = 1'b0;
            end
            if (s_out_fire) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    if (bad < 5) $display("FAIL rand_spurious out_a=%0d exp=none", s_out_a);
                end else begin
                    n_tests++;
                    if (s_out_a !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL rand_out_a[%0d] got=%0d exp=%0d", got, s_out_a, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL rand_protocol got=%0d errors exp=0", bad); end
        n_tests++;
        if (got !== 1000) begin n_fail++; $display("FAIL rand_out_count got=%0d exp=1000", got); end
        n_tests++;
        if (word_cnt !== 8'd232) begin n_fail++; $display("FAIL rand_word_cnt got=%0d exp=232", word_cnt); end
        $display("[TB] random: %0d words in %0d cycles word_cnt=%0d", got, cyc, word_cnt);
    endtask

    task automatic test_reset_mid;
        int sent, cyc, k;
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        do_cycle(1'b0, 1'b1, sxd_encode(4'd3, 4'd4, 4'd5), 4'd4, 4'd5, 1'b1);
        do_cycle(1'b0, 1'b1, sxd_encode(4'd6, 4'd1, 4'd2), 4'd1, 4'd2, 1'b1);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        n_tests++;
        if (word_cnt !== 8'd2) begin n_fail++; $display("FAIL rmid_pre_cnt got=%0d exp=2", word_cnt); end
        sent = 0; cyc = 0;
        while (sent < 3 && cyc < 10) begin
            do_cycle(1'b0, 1'b1, sxd_encode(4'(sent), 4'd7, 4'd1), 4'd7, 4'd1, 1'b0);
            cyc++;
            if (s_in_fire) sent++;
        end
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        n_tests++;
        if (sent !== 3 || s_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rmid_in_flight got=%0d valid=%b exp=3 valid=1", sent, s_out_valid);
        end
        // out_ready high during the reset edge: that transfer must not happen.
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        n_tests++;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got=%b exp=0", s_out_valid); end
        n_tests++;
        if (word_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_word_cnt got=%0d exp=0", word_cnt); end
        do_cycle(1'b0, 1'b1, sxd_encode(4'd11, 4'd13, 4'd6), 4'd13, 4'd6, 1'b1);
        n_tests++;
        if (s_in_fire !== 1'b1) begin n_fail++; $display("FAIL rmid_accept got=%b exp=1", s_in_fire); end
        k = 0;
        do begin
            do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            k++;
        end while (!s_out_valid && k < 10);
        n_tests++;
        if (k !== 3 || s_out_a !== 4'd11) begin
            n_fail++; $display("FAIL rmid_after got=%0d latency=%0d exp=11 latency=3", s_out_a, k);
        end
        n_tests++;
        if (word_cnt !== 8'd1) begin n_fail++; $display("FAIL rmid_cnt_after got=%0d exp=1", word_cnt); end
        $display("[TB] reset_mid: post-reset out_a=%0d latency=%0d word_cnt=%0d", s_out_a, k, word_cnt);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
